// File: rtl/hi_lo_muldiv_controller.sv
`default_nettype none
// ============================================================================
// Module   : hi_lo_muldiv_controller
// Purpose  : Owns the architectural HI/LO registers. Runs the multi-cycle
//            MULT/MULTU (shift-add) and DIV/DIVU (restoring radix-2) ops
//            for the execute stage. Applies MTHI/MTLO writes. Stalls
//            execute while a result is pending and a HI/LO-dependent
//            instruction is waiting in execute.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            op_execute            - 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,
//                                    5 MTHI,6 MTLO,7 NONE
//            flush_execute         - execute-stage op squashed
//            read_hi_lo_execute    - MFHI/MFLO in execute
//            source_a/b_execute    - rs / rt operands
//            HI_output, LO_output  - architectural HI / LO
//            busy                  - sequencer not idle
//            stall_execute         - hold execute and downstream registers
// Revision : 1.0 - initial release
// ============================================================================
module hi_lo_muldiv_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            op_execute,
    input  logic                  flush_execute,
    input  logic                  read_hi_lo_execute,
    input  logic [DATA_WIDTH-1:0] source_a_execute,
    input  logic [DATA_WIDTH-1:0] source_b_execute,
    output logic [DATA_WIDTH-1:0] HI_output,
    output logic [DATA_WIDTH-1:0] LO_output,
    output logic                  busy,
    output logic                  stall_execute
);

    localparam int c_CW = $clog2(DATA_WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DATA_WIDTH - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_MULTIPLY = 2'd1;
    localparam logic [1:0] c_DIVIDE   = 2'd2;
    localparam logic [1:0] c_FINISH   = 2'd3;

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    logic [1:0]              r_state;
    logic [c_CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0]   r_mcand;      // multiplicand magnitude
    logic [2*DATA_WIDTH-1:0] r_prod;       // {partial product, multiplier}
    logic [DATA_WIDTH-1:0]   r_divisor;    // divisor magnitude
    logic [DATA_WIDTH:0]     r_rem;        // remainder plus guard bit
    logic [DATA_WIDTH-1:0]   r_quo;        // dividend shifts out, quotient shifts in
    logic [DATA_WIDTH-1:0]   r_raw_a;      // unmodified dividend for divide-by-zero
    logic                    r_is_div;
    logic                    r_div_zero;
    logic                    r_neg_q;      // product / quotient sign
    logic                    r_neg_r;      // remainder sign
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;

    logic                    w_accept;
    logic                    w_signed_op;
    logic [DATA_WIDTH-1:0]   w_mag_a;
    logic [DATA_WIDTH-1:0]   w_mag_b;
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [DATA_WIDTH:0]     w_div_shift;
    logic [DATA_WIDTH+1:0]   w_div_trial;
    logic                    w_div_ok;
    logic [2*DATA_WIDTH-1:0] w_prod_res;
    logic [DATA_WIDTH-1:0]   w_quo_res;
    logic [DATA_WIDTH-1:0]   w_rem_res;

    assign w_accept    = (r_state == c_IDLE) && !flush_execute;
    assign w_signed_op = (op_execute == c_OP_MULT) || (op_execute == c_OP_DIV);

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
    // magnitude, so no special case is needed for the most negative value.
    assign w_mag_a = (w_signed_op && source_a_execute[DATA_WIDTH-1]) ?
                     -source_a_execute : source_a_execute;
    assign w_mag_b = (w_signed_op && source_b_execute[DATA_WIDTH-1]) ?
                     -source_b_execute : source_b_execute;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier LSB is set, keep the carry, then shift right by one.
    assign w_mul_sum = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, r_mcand};

    // Restoring divide step: bring in the next dividend bit and try the
    // subtraction; the top bit of the trial is its sign.
    assign w_div_shift = {r_rem[DATA_WIDTH-1:0], r_quo[DATA_WIDTH-1]};
    assign w_div_trial = {1'b0, w_div_shift} - {2'b00, r_divisor};
    assign w_div_ok    = !w_div_trial[DATA_WIDTH+1];

    assign w_prod_res = r_neg_q ? -r_prod : r_prod;
    assign w_quo_res  = r_neg_q ? -r_quo : r_quo;
    assign w_rem_res  = r_neg_r ? -r_rem[DATA_WIDTH-1:0] : r_rem[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_mcand    <= '0;
            r_prod     <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_raw_a    <= '0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        case (op_execute)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_mcand    <= w_mag_a;
                                r_prod     <= {{DATA_WIDTH{1'b0}}, w_mag_b};
                                r_neg_q    <= w_signed_op &&
                                              (source_a_execute[DATA_WIDTH-1] ^
                                               source_b_execute[DATA_WIDTH-1]);
                                r_is_div   <= 1'b0;
                                r_div_zero <= 1'b0;
                                r_count    <= '0;
                                r_state    <= c_MULTIPLY;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_quo      <= w_mag_a;
                                r_divisor  <= w_mag_b;
                                r_rem      <= '0;
                                r_raw_a    <= source_a_execute;
                                r_neg_q    <= w_signed_op &&
                                              (source_a_execute[DATA_WIDTH-1] ^
                                               source_b_execute[DATA_WIDTH-1]);
                                r_neg_r    <= w_signed_op && source_a_execute[DATA_WIDTH-1];
                                r_is_div   <= 1'b1;
                                r_count    <= '0;
                                // Divide by zero skips the iterations entirely.
                                if (source_b_execute == '0) begin
                                    r_div_zero <= 1'b1;
                                    r_state    <= c_FINISH;
                                end else begin
                                    r_div_zero <= 1'b0;
                                    r_state    <= c_DIVIDE;
                                end
                            end
                            c_OP_MTHI: r_hi <= source_a_execute;
                            c_OP_MTLO: r_lo <= source_a_execute;
                            default: ;
                        endcase
                    end
                end
                c_MULTIPLY: begin
                    if (r_prod[0]) begin
                        r_prod <= {w_mul_sum, r_prod[DATA_WIDTH-1:1]};
                    end else begin
                        r_prod <= {1'b0, r_prod[2*DATA_WIDTH-1:1]};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_state <= c_FINISH;
                    end
                end
                c_DIVIDE: begin
                    if (w_div_ok) begin
                        r_rem <= w_div_trial[DATA_WIDTH:0];
                    end else begin
                        r_rem <= w_div_shift;
                    end
                    r_quo   <= {r_quo[DATA_WIDTH-2:0], w_div_ok};
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_state <= c_FINISH;
                    end
                end
                default: begin // c_FINISH
                    if (r_div_zero) begin
                        r_hi <= r_raw_a;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem_res;
                        r_lo <= w_quo_res;
                    end else begin
                        r_hi <= w_prod_res[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_lo <= w_prod_res[DATA_WIDTH-1:0];
                    end
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign HI_output     = r_hi;
    assign LO_output     = r_lo;
    assign busy          = (r_state != c_IDLE);
    assign stall_execute = busy && !flush_execute &&
                           (((op_execute >= c_OP_MULT) && (op_execute <= c_OP_MTLO)) ||
                            read_hi_lo_execute);

endmodule
`default_nettype wire

// File: tb/tb_hi_lo_muldiv_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hi_lo_muldiv_controller
// Purpose  : Self-checking bench for hi_lo_muldiv_controller. Expected HI/LO
//            results and busy lengths are queued when an op is issued and
//            compared when the controller returns to idle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hi_lo_muldiv_controller;

    logic        clk;
    logic        reset;
    logic [2:0]  op_execute;
    logic        flush_execute;
    logic        read_hi_lo_execute;
    logic [31:0] source_a_execute;
    logic [31:0] source_b_execute;
    logic [31:0] HI_output;
    logic [31:0] LO_output;
    logic        busy;
    logic        stall_execute;

    hi_lo_muldiv_controller #(.DATA_WIDTH(32)) u_dut (
        .clk                (clk),
        .reset              (reset),
        .op_execute         (op_execute),
        .flush_execute      (flush_execute),
        .read_hi_lo_execute (read_hi_lo_execute),
        .source_a_execute   (source_a_execute),
        .source_b_execute   (source_b_execute),
        .HI_output          (HI_output),
        .LO_output          (LO_output),
        .busy               (busy),
        .stall_execute      (stall_execute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: {HI, LO} after the op, given current {HI, LO}.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb_, sq, sr;
        sa = a;
        sb_ = b;
        case (op)
            3'd1: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = sa / sb_;
                sr = sa % sb_;
                return {sr, sq};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd5: return {a, cur[31:0]};
            3'd6: return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    function automatic int model_cycles(input logic [2:0] op, input logic [31:0] b);
        if (op >= 3'd1 && op <= 3'd4) begin
            if ((op == 3'd3 || op == 3'd4) && b == 32'd0) return 1;
            return 33;
        end
        return 0;
    endfunction

    // Issue one op, then follow it to idle. mflo_at / flush_at name the edge
    // (E1..E33) after which MFLO / a one-cycle flush appear in execute.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int mflo_at, input int flush_at);
        exp_t e;
        int   cycles, stall_bad, hold_bad, k;
        bit   done;
        logic exp_stall;
        @(negedge clk);
        op_execute       = op;
        source_a_execute = a;
        source_b_execute = b;
        e.res = model(op, a, b, {m_hi, m_lo});
        e.cyc = model_cycles(op, b);
        sb.push_back(e);
        @(posedge clk);
        #1 op_execute = 3'd0;
        cycles = 0; stall_bad = 0; hold_bad = 0; k = 0; done = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            exp_stall = busy && !flush_execute && read_hi_lo_execute;
            if (stall_execute !== exp_stall) stall_bad++;
            if (!busy) begin
                done = 1;
            end else begin
                cycles++;
                if (HI_output !== m_hi || LO_output !== m_lo) hold_bad++;
                @(posedge clk);
                #1;
                k++;
                if (k == mflo_at) read_hi_lo_execute = 1'b1;
                flush_execute = (flush_at > 0) && (k == flush_at);
            end
        end
        e = sb.pop_front();
        if (!done) begin
            check({tag, "_timeout"}, 1, 0);
        end else begin
            check({tag, "_busy_cycles"}, 64'(cycles), 64'(e.cyc));
            check({tag, "_hilo"}, {HI_output, LO_output}, e.res);
            check({tag, "_stall"}, 64'(stall_bad), 0);
            check({tag, "_hold"}, 64'(hold_bad), 0);
        end
        m_hi = e.res[63:32];
        m_lo = e.res[31:0];
        read_hi_lo_execute = 1'b0;
        flush_execute      = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        int          stall_cnt;
        int          k;
        reset = 1'b1; op_execute = '0; flush_execute = 1'b0; read_hi_lo_execute = 1'b0;
        source_a_execute = '0; source_b_execute = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 0);
        check("reset_stall", 64'(stall_execute), 0);
        check("reset_hilo", {HI_output, LO_output}, 64'd0);

        run_op("mult",     3'd1, 32'd7,          32'hFFFF_FFFD, 0, 0);
        run_op("multu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0);
        run_op("div_mflo", 3'd3, 32'hFFFF_FFF9,  32'd2,         5, 20);
        run_op("divu",     3'd4, 32'd100,        32'd7,         0, 0);
        run_op("div_ovf",  3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0);
        run_op("divu_z",   3'd4, 32'h0000_1234,  32'd0,         0, 0);
        run_op("div_z",    3'd3, 32'h8765_4321,  32'd0,         0, 0);
        run_op("mult_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_op("rand", 3'($urandom_range(1, 4)), $urandom,
                   $urandom >> $urandom_range(0, 31), 0, 0);
        end

        // Reset in the middle of a multiply abandons it.
        @(negedge clk);
        op_execute = 3'd1; source_a_execute = 32'd123; source_b_execute = 32'd456;
        @(posedge clk);
        #1 op_execute = 3'd0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 0);
        check("midreset_hilo", {HI_output, LO_output}, 64'd0);
        m_hi = '0; m_lo = '0;

        // MTHI while idle: no stall, one edge of latency.
        @(negedge clk);
        op_execute = 3'd5; source_a_execute = 32'hCAFE_F00D;
        check("mthi_stall", 64'(stall_execute), 0);
        run_op("mthi", 3'd5, 32'hCAFE_F00D, 32'd0, 0, 0);

        // MTLO held behind a multiply, applied on the edge after E33.
        @(negedge clk);
        op_execute = 3'd1; source_a_execute = 32'hFFFF_0003; source_b_execute = 32'd9;
        r = model(3'd1, 32'hFFFF_0003, 32'd9, {m_hi, m_lo});
        @(posedge clk);
        #1 op_execute = 3'd6; source_a_execute = 32'h1357_9BDF;
        stall_cnt = 0; k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            if (stall_execute === 1'b1) stall_cnt++;
            k++;
            @(negedge clk);
        end
        check("mtlo_stall_cycles", 64'(stall_cnt), 33);
        check("mtlo_stall_release", 64'(stall_execute), 0);
        check("mtlo_pending_hilo", {HI_output, LO_output}, r);
        @(posedge clk);
        #1 op_execute = 3'd0;
        @(negedge clk);
        check("mtlo_applied", {HI_output, LO_output}, {r[63:32], 32'h1357_9BDF});
        check("mtlo_busy", 64'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
